alu_seq: RTL

//  Registered, parametrised-width successor of the 4-bit combinational ALU. Same

---
 rtl/alu_seq_pkg.sv | 33 +++
 rtl/alu_seq_core.sv | 79 +++++++
 rtl/alu_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the registered ALU: group/op codes and FSM states.
// Imported by alu_seq and alu_seq_core.
package alu_seq_pkg;

  localparam logic L_ARITH = 1'b0;
  localparam logic L_LOGIC = 1'b1;

  typedef enum logic [2:0] {
    OP_INC = 3'd0,
    OP_NEG = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_ADC = 3'd4,
    OP_SBC = 3'd5,
    OP_MUL = 3'd6,
    OP_RSV = 3'd7
  } arith_op_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  function automatic logic is_mul(input logic l, input logic [2:0] op);
    return (l == L_ARITH) && (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational adder/logic unit: a, b, l, op, cin -> r, c, v.
// MUL and reserved codes yield zero with clear flags.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [WIDTH-1:0] r,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             ci;
  logic             use_add;
  logic [WIDTH-1:0] lr;
  logic [WIDTH:0]   sum;

  always_comb begin
    x       = '0;
    y       = '0;
    ci      = 1'b0;
    use_add = 1'b0;
    lr      = '0;
    if (l == L_ARITH) begin
      case (op)
        OP_INC: begin
          x = b; ci = 1'b1; use_add = 1'b1;
        end
        OP_NEG: begin
          y = ~b; ci = 1'b1; use_add = 1'b1;
        end
        OP_ADD: begin
          x = a; y = b; use_add = 1'b1;
        end
        OP_SUB: begin
          x = a; y = ~b; ci = 1'b1; use_add = 1'b1;
        end
        OP_ADC: begin
          x = a; y = b; ci = cin; use_add = 1'b1;
        end
        OP_SBC: begin
          x = a; y = ~b; ci = cin; use_add = 1'b1;
        end
        default: use_add = 1'b0;
      endcase
    end else begin
      case (op)
        OP_AND:  lr = a & b;
        OP_OR:   lr = a | b;
        OP_XOR:  lr = a ^ b;
        OP_NOT:  lr = ~a;
        default: lr = '0;
      endcase
    end
  end

  assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

  always_comb begin
    r = lr;
    c = 1'b0;
    v = 1'b0;
    if (use_add) begin
      r = sum[WIDTH-1:0];
      c = sum[WIDTH];
      // Overflow: like-signed operands producing an opposite-signed result.
      v = (x[WIDTH-1] == y[WIDTH-1]) &&
          (sum[WIDTH-1] != x[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready front end and a WIDTH-cycle
// shift-add multiplier; results and flags hold until the next result.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             l,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             c,
  output logic             s,
  output logic             v
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               z_q, z_d;
  logic               c_q, c_d;
  logic               s_q, s_d;
  logic               v_q, v_d;
  logic               ov_q, ov_d;

  logic               accept;
  logic               mul_req;
  logic [WIDTH-1:0]   core_r;
  logic               core_c;
  logic               core_v;
  logic [2*WIDTH-1:0] acc_nxt;
  logic               wr;
  logic [WIDTH-1:0]   res_r;
  logic               res_c;
  logic               res_v;

  assign accept  = in_valid & in_ready;
  assign mul_req = is_mul(l, op);

  alu_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a  (a),
    .b  (b),
    .l  (l),
    .op (op),
    .cin(c_q),
    .r  (core_r),
    .c  (core_c),
    .v  (core_v)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      r_q      <= '0;
      z_q      <= 1'b1;
      c_q      <= 1'b0;
      s_q      <= 1'b0;
      v_q      <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      r_q      <= r_d;
      z_q      <= z_d;
      c_q      <= c_d;
      s_q      <= s_d;
      v_q      <= v_d;
      ov_q     <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && mul_req) state_d = S_MUL;
      S_MUL:  if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    wr       = 1'b0;
    res_r    = '0;
    res_c    = 1'b0;
    res_v    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && mul_req) begin
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH - 1);
        end else if (accept) begin
          wr    = 1'b1;
          res_r = core_r;
          res_c = core_c;
          res_v = core_v;
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          wr    = 1'b1;
          res_r = acc_nxt[WIDTH-1:0];
          res_c = |acc_nxt[2*WIDTH-1:WIDTH];
          res_v = |acc_nxt[2*WIDTH-1:WIDTH];
        end
      end
      default: wr = 1'b0;
    endcase
  end

  always_comb begin
    r_d  = r_q;
    z_d  = z_q;
    c_d  = c_q;
    s_d  = s_q;
    v_d  = v_q;
    ov_d = 1'b0;
    if (wr) begin
      r_d  = res_r;
      z_d  = ~|res_r;
      s_d  = res_r[WIDTH-1];
      c_d  = res_c;
      v_d  = res_v;
      ov_d = 1'b1;
    end
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = ov_q;
    r         = r_q;
    z         = z_q;
    c         = c_q;
    s         = s_q;
    v         = v_q;
  end

endmodule
